hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core, the control partner of the bypass network.

---
 rtl/hazard_stall_ctrl_pkg.sv | 31 +++
 rtl/hazard_stall_ctrl_scoreboard.sv | 62 ++++++
 rtl/hazard_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, register
// constants, mult/div latency default and the scoreboard entry format.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_MDWAIT  = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MULDIV_LAT_DEF = 32;

    // One in-flight instruction as the hazard logic sees it.
    typedef struct packed {
        logic [4:0] dest;
        logic       load;
    } sb_entry_t;

    // Scoreboard image of the NOP that bubble insertion places in ID/EX.
    localparam sb_entry_t SB_NOP = '{dest: REG_ZERO, load: 1'b0};

    // A producer matches a source only if it really writes a non-zero register
    // and the consumer really reads that source.
    function automatic logic src_match(input logic [4:0] dest,
                                       input logic       used,
                                       input logic [4:0] src);
        return (dest != REG_ZERO) && used && (dest == src);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_scoreboard.sv
// Two-entry destination scoreboard (EX and MEM stage) with source compare
// against the instruction currently decoded in ID.
module hazard_stall_ctrl_scoreboard
    import hazard_stall_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       ex_bubble,
    input  logic       id_valid,
    input  logic [4:0] id_dest,
    input  logic       id_mem_read,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    output logic       ex_match,
    output logic       ex_load,
    output logic       mem_match,
    output logic       mem_load
);

    sb_entry_t sb_ex_q, sb_ex_d;
    sb_entry_t sb_mem_q, sb_mem_d;

    // Shift the entries along with the pipeline; a bubble or empty ID slot enters as a NOP.
    always_comb begin
        sb_ex_d  = sb_ex_q;
        sb_mem_d = sb_mem_q;
        if (advance) begin
            sb_mem_d = sb_ex_q;
            if (ex_bubble || !id_valid) begin
                sb_ex_d = SB_NOP;
            end else begin
                sb_ex_d.dest = id_dest;
                sb_ex_d.load = id_mem_read;
            end
        end
    end

    // Scoreboard registers, cleared so that nothing stale can stall after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_ex_q  <= SB_NOP;
            sb_mem_q <= SB_NOP;
        end else begin
            sb_ex_q  <= sb_ex_d;
            sb_mem_q <= sb_mem_d;
        end
    end

    // Compare both in-flight destinations against the ID sources.
    always_comb begin
        ex_match  = src_match(sb_ex_q.dest, id_uses_rs, id_rs) ||
                    src_match(sb_ex_q.dest, id_uses_rt, id_rt);
        mem_match = src_match(sb_mem_q.dest, id_uses_rs, id_rs) ||
                    src_match(sb_mem_q.dest, id_uses_rt, id_rt);
        ex_load   = sb_ex_q.load;
        mem_load  = sb_mem_q.load;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: detects hazards the bypass network
// cannot cover and drives per-stage stall / bubble / freeze controls.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [4:0]       ID_Dest,
    input  logic             ID_MemRead,
    input  logic             ID_Branch,
    input  logic             ID_MulDiv,
    input  logic             ID_HiLoRd,
    input  logic             IMEM_Busy,
    input  logic             DMEM_Busy,
    output logic             IF_Stall,
    output logic             ID_Stall,
    output logic             EX_Bubble,
    output logic             ID_Bubble,
    output logic             Pipe_Freeze,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] Stall_Cnt
);

    localparam int MDC_W = $clog2(MULDIV_LAT + 1);
    // The issue cycle is the first of the MULDIV_LAT cycles, so after the issuing
    // edge MULDIV_LAT-1 cycles remain; HI/LO may be read when the count hits 0.
    localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MULDIV_LAT - 1);

    state_e             state_q, state_d;
    logic [MDC_W-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic sb_ex_match, sb_ex_load, sb_mem_match, sb_mem_load;
    logic lu_hz, br_hz, md_hz, hz, mdwait_hold, md_issue;

    hazard_stall_ctrl_scoreboard u_scoreboard (
        .clk         (CLK),
        .rst_n       (RESET),
        .advance     (!Pipe_Freeze),
        .ex_bubble   (EX_Bubble),
        .id_valid    (ID_Valid),
        .id_dest     (ID_Dest),
        .id_mem_read (ID_MemRead),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .id_uses_rs  (ID_UsesRs),
        .id_uses_rt  (ID_UsesRt),
        .ex_match    (sb_ex_match),
        .ex_load     (sb_ex_load),
        .mem_match   (sb_mem_match),
        .mem_load    (sb_mem_load)
    );

    // Hazard terms, evaluated in the same cycle the instruction sits in ID.
    always_comb begin
        MD_Busy     = (md_cnt_q != '0);
        lu_hz       = sb_ex_load && sb_ex_match;
        br_hz       = ID_Branch && (sb_ex_match || (sb_mem_load && sb_mem_match));
        md_hz       = (ID_HiLoRd || ID_MulDiv) && MD_Busy;
        hz          = ID_Valid && (lu_hz || br_hz || md_hz);
        mdwait_hold = (state_q == ST_MDWAIT) && MD_Busy;
    end

    // Stall controls by priority: memory wait freezes everything, then hazards, then fetch wait.
    always_comb begin
        IF_Stall    = 1'b0;
        ID_Stall    = 1'b0;
        EX_Bubble   = 1'b0;
        ID_Bubble   = 1'b0;
        Pipe_Freeze = 1'b0;
        if (RESET) begin
            if (DMEM_Busy) begin
                Pipe_Freeze = 1'b1;
                IF_Stall    = 1'b1;
                ID_Stall    = 1'b1;
            end else if (hz || mdwait_hold) begin
                IF_Stall    = 1'b1;
                ID_Stall    = 1'b1;
                EX_Bubble   = 1'b1;
            end else if (IMEM_Busy) begin
                IF_Stall    = 1'b1;
                ID_Bubble   = 1'b1;
            end
        end
    end

    // Sequencer state tracking memory wait and mult/div wait.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (DMEM_Busy)               state_d = ST_MEMWAIT;
                else if (ID_Valid && md_hz)  state_d = ST_MDWAIT;
            end
            ST_MEMWAIT: begin
                if (!DMEM_Busy)              state_d = ST_RUN;
            end
            ST_MDWAIT: begin
                if (DMEM_Busy)               state_d = ST_MEMWAIT;
                else if (!MD_Busy)           state_d = ST_RUN;
            end
            default:                         state_d = ST_RUN;
        endcase
    end

    // Mult/div countdown reloads on an accepted issue and otherwise runs free, even when frozen.
    always_comb begin
        md_issue = ID_Valid && ID_MulDiv && !ID_Stall;
        md_cnt_d = md_cnt_q;
        if (md_issue) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MDC_W'(1);
        end
    end

    // Saturating count of cycles lost to any stall or freeze.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((IF_Stall || Pipe_Freeze) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        Stall_Cnt = stall_cnt_q;
    end

    // Control state registers; reset clears any pending stall immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: each cycle the expected control vector
// is queued with the stimulus and popped/compared mid-cycle.
module tb_hazard_stall_ctrl;

    localparam int LAT   = 32;
    localparam int CNT_W = 5;

    // Expected vector bits: {IF_Stall, ID_Stall, EX_Bubble, ID_Bubble, Pipe_Freeze, MD_Busy}
    localparam logic [5:0] E_NONE = 6'b000000;
    localparam logic [5:0] E_HZ   = 6'b111000;
    localparam logic [5:0] E_HZMD = 6'b111001;
    localparam logic [5:0] E_FRZ  = 6'b110010;
    localparam logic [5:0] E_IMEM = 6'b100100;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             ID_Valid, ID_UsesRs, ID_UsesRt, ID_MemRead, ID_Branch, ID_MulDiv, ID_HiLoRd;
    logic [4:0]       ID_Rs, ID_Rt, ID_Dest;
    logic             IMEM_Busy, DMEM_Busy;
    logic             IF_Stall, ID_Stall, EX_Bubble, ID_Bubble, Pipe_Freeze, MD_Busy;
    logic [CNT_W-1:0] Stall_Cnt;

    logic [5:0]       exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    int               n_tests;
    int               n_fail;

    hazard_stall_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Dest(ID_Dest),
        .ID_MemRead(ID_MemRead), .ID_Branch(ID_Branch), .ID_MulDiv(ID_MulDiv),
        .ID_HiLoRd(ID_HiLoRd), .IMEM_Busy(IMEM_Busy), .DMEM_Busy(DMEM_Busy),
        .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EX_Bubble(EX_Bubble),
        .ID_Bubble(ID_Bubble), .Pipe_Freeze(Pipe_Freeze), .MD_Busy(MD_Busy),
        .Stall_Cnt(Stall_Cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Queue the expectation, compare on the falling edge, return just after the rising edge.
    task automatic step(input string tag, input logic [5:0] e);
        logic [5:0] x;
        exp_q.push_back(e);
        @(negedge CLK);
        x = exp_q.pop_front();
        check({tag, ":ctl"}, {26'd0, IF_Stall, ID_Stall, EX_Bubble, ID_Bubble, Pipe_Freeze, MD_Busy},
              {26'd0, x});
        check({tag, ":cnt"}, {{(32-CNT_W){1'b0}}, Stall_Cnt}, {{(32-CNT_W){1'b0}}, exp_cnt});
        if ((x[5] || x[1]) && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic [4:0] dest,
                          input logic ld, input logic br, input logic md, input logic hl);
        ID_Valid = v;  ID_Rs = rs; ID_UsesRs = urs; ID_Rt = rt; ID_UsesRt = urt;
        ID_Dest = dest; ID_MemRead = ld; ID_Branch = br; ID_MulDiv = md; ID_HiLoRd = hl;
    endtask

    task automatic i_none();                               id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic i_nop();                                id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic i_alu(input logic [4:0] rs, rt, dest);  id_set(1, rs, 1, rt, 1, dest, 0, 0, 0, 0); endtask
    task automatic i_lw(input logic [4:0] base, dest);     id_set(1, base, 1, 0, 0, dest, 1, 0, 0, 0); endtask
    task automatic i_br(input logic [4:0] rs, rt);         id_set(1, rs, 1, rt, 1, 0, 0, 1, 0, 0); endtask
    task automatic i_mult(input logic [4:0] rs, rt);       id_set(1, rs, 1, rt, 1, 0, 0, 0, 1, 0); endtask
    task automatic i_mflo(input logic [4:0] dest);         id_set(1, 0, 0, 0, 0, dest, 0, 0, 0, 1); endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = '0;
        RESET   = 1'b0;
        IMEM_Busy = 1'b1;
        DMEM_Busy = 1'b1;
        i_mflo(5'd3);

        // Reset held with busy inputs: all controls must stay low.
        step("rst_hold", E_NONE);
        RESET = 1'b1;
        IMEM_Busy = 1'b0;
        DMEM_Busy = 1'b0;
        i_none();
        step("idle", E_NONE);

        // Load-use: lw $8 ; add $9,$8,$1
        i_lw(5'd29, 5'd8);      step("lu_lw",   E_NONE);
        i_alu(5'd8, 5'd1, 5'd9); step("lu_stall", E_HZ);
        step("lu_issue", E_NONE);
        i_none();               step("lu_after", E_NONE);

        // Branch on ALU result in EX: add $8 ; beq $8,$0
        i_alu(5'd1, 5'd2, 5'd8); step("br_add",   E_NONE);
        i_br(5'd8, 5'd0);        step("br_stall", E_HZ);
        step("br_issue", E_NONE);

        // Branch on load in MEM: lw $8 ; nop ; beq $8
        i_lw(5'd29, 5'd8);       step("brm_lw",    E_NONE);
        i_nop();                 step("brm_nop",   E_NONE);
        i_br(5'd8, 5'd0);        step("brm_stall", E_HZ);
        step("brm_issue", E_NONE);

        // Register zero never creates a hazard: add $0 ; beq $0,$0
        i_alu(5'd1, 5'd2, 5'd0); step("br0_add", E_NONE);
        i_br(5'd0, 5'd0);        step("br0_beq", E_NONE);

        // Branch right after a load: two bubbles
        i_lw(5'd29, 5'd8);       step("br2_lw",  E_NONE);
        i_br(5'd8, 5'd0);        step("br2_s1",  E_HZ);
        step("br2_s2",    E_HZ);
        step("br2_issue", E_NONE);

        // Data memory wait for 3 cycles on top of a load-use hazard
        i_lw(5'd29, 5'd8);       step("frz_lw", E_NONE);
        i_alu(5'd8, 5'd1, 5'd9);
        DMEM_Busy = 1'b1;
        for (int i = 0; i < 3; i++) step("frz_hold", E_FRZ);
        DMEM_Busy = 1'b0;
        step("frz_lu",    E_HZ);
        step("frz_issue", E_NONE);

        // Fetch wait alone for 2 cycles; ID keeps advancing, then hazard beats fetch wait
        IMEM_Busy = 1'b1;
        i_alu(5'd1, 5'd2, 5'd10); step("im_alu", E_IMEM);
        i_lw(5'd29, 5'd11);       step("im_lw",  E_IMEM);
        i_alu(5'd11, 5'd1, 5'd12); step("im_hz", E_HZ);
        IMEM_Busy = 1'b0;
        step("im_issue", E_NONE);

        // mult then mflo: MULDIV_LAT-1 stall cycles, counter saturates
        i_mult(5'd1, 5'd2);      step("md_mult", E_NONE);
        i_mflo(5'd13);
        for (int i = 0; i < LAT - 1; i++) step("md_wait", E_HZMD);
        step("md_issue", E_NONE);
        i_none();                step("md_idle", E_NONE);

        // mult restart while busy, then reset in MDWAIT
        i_mult(5'd1, 5'd2);      step("rs_mult",  E_NONE);
        i_mult(5'd3, 5'd4);      step("rs_again", E_HZMD);
        i_mflo(5'd13);           step("rs_mflo",  E_HZMD);
        RESET     = 1'b0;
        DMEM_Busy = 1'b1;
        exp_cnt   = '0;
        step("rs_low", E_NONE);
        RESET     = 1'b1;
        DMEM_Busy = 1'b0;
        step("rs_mflo_go", E_NONE);
        i_none();                step("rs_idle", E_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
